// File: rtl/frame_update_scheduler.sv
// frame_update_scheduler
//   Hands out per-frame update slots to the game-logic clients during vertical
//   blanking. A falling edge of vSync starts a sequence that visits every client
//   in index order. Enabled clients are granted one at a time with a req/done
//   handshake. A deadline counter aborts the sequence if blanking would end first.
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   vSync             active-low vertical sync from the VGA timing generator
//   pause             suppresses frame starts while high
//   clientMask        per-client enable, latched at frame start
//   updateDone        per-client completion; only the granted bit is looked at
//   updateReq         registered one-hot grant
//   busy              sequence in progress (SCAN or GRANT)
//   frameStart        one-cycle pulse in the first cycle of a sequence
//   frameCount        started sequences, wrapping
//   overrun           sticky deadline-expiry flag, cleared by clearOverrun
//   clearOverrun      clears overrun (a simultaneous set wins)
//   overrunCount      saturating overrun count, cleared only by rst
module frame_update_scheduler #(
  parameter int N_CLIENTS       = 4,
  parameter int DEADLINE_CYCLES = 49600,
  parameter int DL_WIDTH        = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vSync,
  input  logic                 pause,
  input  logic [N_CLIENTS-1:0] clientMask,
  input  logic [N_CLIENTS-1:0] updateDone,
  output logic [N_CLIENTS-1:0] updateReq,
  output logic                 busy,
  output logic                 frameStart,
  output logic [15:0]          frameCount,
  output logic                 overrun,
  input  logic                 clearOverrun,
  output logic [7:0]           overrunCount
);

  localparam int SW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, GRANT} state_t;

  state_t               state, stateNext;
  logic                 vSyncPrev;
  logic [SW-1:0]        slot;
  logic [N_CLIENTS-1:0] maskQ;
  logic [N_CLIENTS-1:0] aboveMask;
  logic [DL_WIDTH-1:0]  deadline;

  logic frameEdge, lastSlot, moreEnabled, dlZero;
  logic startSeq, advance, grantNow, overrunSet;

  assign frameEdge = vSyncPrev & ~vSync;
  assign lastSlot  = (slot == SW'(N_CLIENTS - 1));
  assign dlZero    = (deadline == '0);
  assign busy      = (state != IDLE);

  // Clients above the current slot; used to tell whether the sequence has
  // effectively finished when the deadline runs out.
  always_comb begin
    aboveMask = '0;
    for (int i = 0; i < N_CLIENTS; i++) aboveMask[i] = (i > int'(slot));
  end
  assign moreEnabled = |(maskQ & aboveMask);

  always_comb begin
    stateNext  = state;
    startSeq   = 1'b0;
    advance    = 1'b0;
    grantNow   = 1'b0;
    overrunSet = 1'b0;
    case (state)
      IDLE: begin
        if (frameEdge && !pause) begin
          stateNext = SCAN;
          startSeq  = 1'b1;
        end
      end
      SCAN: begin
        if (maskQ[slot]) begin
          if (dlZero) begin
            stateNext  = IDLE;
            overrunSet = 1'b1;
          end else begin
            stateNext = GRANT;
            grantNow  = 1'b1;
          end
        end else if (lastSlot || (dlZero && !moreEnabled)) begin
          stateNext = IDLE;
        end else if (dlZero) begin
          stateNext  = IDLE;
          overrunSet = 1'b1;
        end else begin
          stateNext = SCAN;
          advance   = 1'b1;
        end
      end
      GRANT: begin
        // A done landing on the deadline cycle still counts; it only avoids
        // an overrun if nothing enabled remains after it.
        if (updateDone[slot]) begin
          if (lastSlot || (dlZero && !moreEnabled)) begin
            stateNext = IDLE;
          end else if (dlZero) begin
            stateNext  = IDLE;
            overrunSet = 1'b1;
          end else begin
            stateNext = SCAN;
            advance   = 1'b1;
          end
        end else if (dlZero) begin
          stateNext  = IDLE;
          overrunSet = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      vSyncPrev    <= 1'b1;
      slot         <= '0;
      maskQ        <= '0;
      deadline     <= '0;
      updateReq    <= '0;
      frameStart   <= 1'b0;
      frameCount   <= '0;
      overrun      <= 1'b0;
      overrunCount <= '0;
    end else begin
      state      <= stateNext;
      vSyncPrev  <= vSync;
      frameStart <= startSeq;

      if (startSeq) begin
        slot       <= '0;
        maskQ      <= clientMask;
        deadline   <= DL_WIDTH'(DEADLINE_CYCLES - 1);
        frameCount <= frameCount + 16'd1;
      end else begin
        if (advance) slot <= slot + SW'(1);
        if (state != IDLE && !dlZero) deadline <= deadline - DL_WIDTH'(1);
      end

      if (grantNow)                updateReq <= N_CLIENTS'(1) << slot;
      else if (stateNext != GRANT) updateReq <= '0;

      if (overrunSet) begin
        overrun <= 1'b1;
        if (overrunCount != 8'hFF) overrunCount <= overrunCount + 8'd1;
      end else if (clearOverrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule
